scaler_h_core: RTL and testbench

Horizontal video scaler for a 12-bit single-component pixel stream. Pixels arrive with a data-enable strobe and line/frame markers on the first pixel. The block resamples each line by a programmable fixed-point step using 2-tap linear interpolation between adjacent input pixels. It sits in the video pipeline ahead of the vertical scaler and emits a gapped stream in the same marker format.

---
 rtl/scaler_h_core.sv | 145 ++++++++++++++
 tb/tb_scaler_h_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_h_core.sv
// Horizontal 2-tap linear-interpolation scaler for a 12-bit pixel stream.
// Three register stages: input/segment state, decision+multiply, sum/round/output.
module scaler_h_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] scale_step_h,
    input  logic [11:0] di_i,
    input  logic        de_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [11:0] do_o,
    output logic        de_o,
    output logic        hs_o,
    output logic        vs_o
);

    typedef enum logic [1:0] {SEG_WAIT, SEG_RUN, SEG_DRAIN} seg_state_t;

    seg_state_t  seg_state;
    logic [11:0] prev;
    logic [11:0] cur;
    logic [16:0] acc;
    logic [15:0] step;
    logic        line_active;
    logic        hs_pend;
    logic        vs_pend;

    logic        s2_de;
    logic        s2_hs;
    logic        s2_vs;
    logic [24:0] s2_p0;
    logic [23:0] s2_p1;

    logic        line_start;
    logic        pixel_in;
    logic        acc_ge;
    logic        acc_ge2;
    logic [15:0] step_in;
    logic [12:0] wt_prev;

    assign line_start = de_i & hs_i;
    assign pixel_in   = de_i & ~hs_i & line_active;
    assign acc_ge     = (acc[16:12] != 5'd0);
    assign acc_ge2    = (acc[16:13] != 4'd0);
    assign step_in    = (scale_step_h < 16'd1024) ? 16'd1024 : scale_step_h;
    assign wt_prev    = 13'd4096 - {1'b0, acc[11:0]};

    // A pixel arrival always takes priority over the segment decision of the same clock;
    // an arrival that interrupts an unfinished burst sends the old segment into DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_state   <= SEG_WAIT;
            prev        <= 12'd0;
            cur         <= 12'd0;
            acc         <= 17'd0;
            step        <= 16'd0;
            line_active <= 1'b0;
            hs_pend     <= 1'b0;
            vs_pend     <= 1'b0;
            s2_de       <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
        end else begin
            s2_de <= 1'b0;
            s2_hs <= 1'b0;
            s2_vs <= 1'b0;
            if (line_start) begin
                cur         <= di_i;
                acc         <= 17'd0;
                step        <= step_in;
                line_active <= 1'b1;
                hs_pend     <= 1'b1;
                vs_pend     <= vs_i;
                seg_state   <= SEG_WAIT;
            end else if (pixel_in) begin
                prev <= cur;
                cur  <= di_i;
                case (seg_state)
                    SEG_RUN: begin
                        if (acc_ge) begin
                            acc <= acc - 17'd4096;
                        end else begin
                            seg_state <= SEG_DRAIN;
                        end
                    end
                    SEG_DRAIN: seg_state <= SEG_DRAIN;
                    default:   seg_state <= SEG_RUN;
                endcase
            end else begin
                case (seg_state)
                    SEG_RUN: begin
                        if (acc_ge) begin
                            acc       <= acc - 17'd4096;
                            seg_state <= SEG_WAIT;
                        end else begin
                            acc     <= acc + {1'b0, step};
                            s2_de   <= 1'b1;
                            s2_hs   <= hs_pend;
                            s2_vs   <= vs_pend;
                            hs_pend <= 1'b0;
                            vs_pend <= 1'b0;
                        end
                    end
                    SEG_DRAIN: begin
                        if (acc_ge) begin
                            acc <= acc - 17'd4096;
                            if (!acc_ge2) begin
                                seg_state <= SEG_RUN;
                            end
                        end else begin
                            acc <= acc + {1'b0, step};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tap products are computed every clock; only those qualified by s2_de reach the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_p0 <= 25'd0;
            s2_p1 <= 24'd0;
        end else begin
            s2_p0 <= 25'(prev) * 25'(wt_prev);
            s2_p1 <= 24'(cur) * 24'(acc[11:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_o <= 12'd0;
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            de_o <= s2_de;
            hs_o <= s2_hs;
            vs_o <= s2_vs;
            do_o <= s2_de ? 12'((s2_p0 + {1'b0, s2_p1} + 25'd2048) >> 12) : 12'd0;
        end
    end

endmodule

// File: tb/tb_scaler_h_core.sv
// Self-checking bench for scaler_h_core: directed and randomized lines checked against
// a source-position model (output k at k*step, emitted 3 clocks after its right tap arrives).
module tb_scaler_h_core;

    typedef struct packed {
        int         cyc;
        logic [11:0] d;
        logic       hs;
        logic       vs;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] scale_step_h;
    logic [11:0] di_i;
    logic        de_i;
    logic        hs_i;
    logic        vs_i;
    logic [11:0] do_o;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;

    int  cyc;
    int  compared;
    int  mismatched;
    ev_t obs[$];
    ev_t exp_q[$];

    scaler_h_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scale_step_h (scale_step_h),
        .di_i         (di_i),
        .de_i         (de_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .do_o         (do_o),
        .de_o         (de_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output pixel; between pixels the data and markers must read zero.
    always @(negedge clk) begin
        ev_t e;
        if (de_o) begin
            e.cyc = cyc;
            e.d   = do_o;
            e.hs  = hs_o;
            e.vs  = vs_o;
            obs.push_back(e);
        end else begin
            compared++;
            assert ({do_o, hs_o, vs_o} === 14'd0)
            else begin
                mismatched++;
                $error("[TB] FAIL idle_zero: observed d=%0d hs=%0b vs=%0b, expected all 0", do_o, hs_o, vs_o);
            end
        end
    end

    // Drive one line and append the model's expected outputs for it.
    task automatic apply_stimulus(input int n, input int stp, input bit vs, input bit rnd,
                                  input int spc, input int mid_step);
        int          eff;
        int          gap;
        int          wait_k;
        int          pos;
        int          i;
        int          f;
        int          b;
        int          last_i;
        int          val;
        int          px[$];
        int          dcyc[$];
        ev_t         e;
        eff = (stp < 1024) ? 1024 : stp;
        gap = (4096 + eff - 1) / eff + 1;
        scale_step_h = 16'(stp);
        for (int x = 0; x < n; x++) begin
            @(posedge clk);
            #1;
            px.push_back(rnd ? int'($urandom_range(0, 4095)) : x * 100);
            di_i = 12'(px[x]);
            de_i = 1'b1;
            hs_i = (x == 0);
            vs_i = (x == 0) && vs;
            dcyc.push_back(cyc);
            @(posedge clk);
            #1;
            de_i = 1'b0;
            di_i = 12'($urandom);
            hs_i = 1'($urandom);
            vs_i = 1'($urandom);
            if (x == 0 && mid_step >= 0) scale_step_h = 16'(mid_step);
            wait_k = (spc > 0) ? spc - 2 : gap - 2 + int'($urandom_range(0, 2));
            repeat (wait_k) @(posedge clk);
        end
        #1;
        hs_i = 1'b0;
        vs_i = 1'b0;
        repeat (10) @(posedge clk);
        last_i = -1;
        b = 0;
        for (int k = 0; k * eff < (n - 1) * 4096; k++) begin
            pos = k * eff;
            i   = pos / 4096;
            f   = pos % 4096;
            b   = (i == last_i) ? b + 1 : 0;
            last_i = i;
            val = (px[i] * (4096 - f) + px[i + 1] * f + 2048) / 4096;
            e.cyc = dcyc[i + 1] + 3 + b;
            e.d   = 12'(val);
            e.hs  = (k == 0);
            e.vs  = (k == 0) && vs;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_output(input string tag);
        int m;
        compared++;
        assert (obs.size() === exp_q.size())
        else begin
            mismatched++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, obs.size(), exp_q.size());
        end
        m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int k = 0; k < m; k++) begin
            compared++;
            assert (obs[k] === exp_q[k])
            else begin
                mismatched++;
                $error("[TB] FAIL %s[%0d]: observed cyc=%0d d=%0d hs=%0b vs=%0b, expected cyc=%0d d=%0d hs=%0b vs=%0b",
                       tag, k, obs[k].cyc, obs[k].d, obs[k].hs, obs[k].vs,
                       exp_q[k].cyc, exp_q[k].d, exp_q[k].hs, exp_q[k].vs);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        cyc          = 0;
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        scale_step_h = 16'd4096;
        di_i         = 12'd0;
        de_i         = 1'b0;
        hs_i         = 1'b0;
        vs_i         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        assert ({do_o, de_o, hs_o, vs_o} === 15'd0)
        else begin
            mismatched++;
            $error("[TB] FAIL reset_state: observed %0h expected 0", {do_o, de_o, hs_o, vs_o});
        end
        rst_n = 1'b1;

        // Pixels before any line start are ignored.
        for (int x = 0; x < 4; x++) begin
            @(posedge clk);
            #1;
            di_i = 12'(x * 500 + 7);
            de_i = 1'b1;
            @(posedge clk);
            #1;
            de_i = 1'b0;
            repeat (2) @(posedge clk);
        end
        repeat (8) @(posedge clk);
        check_output("no_hs");

        apply_stimulus(24, 4096, 1'b1, 1'b0, 4, -1);
        check_output("identity_frame");
        apply_stimulus(24, 4096, 1'b0, 1'b0, 4, -1);
        check_output("identity");
        apply_stimulus(24, 6826, 1'b0, 1'b0, 4, -1);
        check_output("downscale");
        apply_stimulus(24, 2048, 1'b0, 1'b0, 4, -1);
        check_output("upscale");

        apply_stimulus(1, 3000, 1'b1, 1'b1, 0, -1);
        check_output("one_pixel");
        apply_stimulus(8, 5000, 1'b0, 1'b1, 0, -1);
        check_output("after_one_pixel");

        apply_stimulus(16, 4096, 1'b0, 1'b1, 4, 2048);
        check_output("step_latch_old");
        apply_stimulus(16, 2048, 1'b0, 1'b1, 4, -1);
        check_output("step_latch_new");

        apply_stimulus(10, 300, 1'b0, 1'b1, 0, -1);
        check_output("clamp_low");
        apply_stimulus(12, 20000, 1'b1, 1'b1, 0, -1);
        check_output("skip_high");

        for (int r = 0; r < 6; r++) begin
            apply_stimulus(int'($urandom_range(2, 20)), int'($urandom_range(1024, 14000)),
                           1'($urandom), 1'b1, 0, -1);
            check_output("random_line");
        end

        // Reset in the middle of an upscale burst.
        scale_step_h = 16'd2048;
        for (int x = 0; x < 3; x++) begin
            @(posedge clk);
            #1;
            di_i = 12'(x * 300);
            de_i = 1'b1;
            hs_i = (x == 0);
            @(posedge clk);
            #1;
            de_i = 1'b0;
            hs_i = 1'b0;
            repeat (2) @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        assert ({do_o, de_o, hs_o, vs_o} === 15'd0)
        else begin
            mismatched++;
            $error("[TB] FAIL mid_reset: observed %0h expected 0", {do_o, de_o, hs_o, vs_o});
        end
        obs.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int x = 0; x < 3; x++) begin
            @(posedge clk);
            #1;
            di_i = 12'(x * 900);
            de_i = 1'b1;
            @(posedge clk);
            #1;
            de_i = 1'b0;
            repeat (2) @(posedge clk);
        end
        repeat (8) @(posedge clk);
        check_output("orphan_after_reset");
        apply_stimulus(14, 3000, 1'b1, 1'b1, 0, -1);
        check_output("line_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
